// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Turns field-level instruction requests into 32-bit MIPS-style words and
//   queues them in a small output FIFO. Supported kinds are R-format, lw, sw,
//   beq and, optionally, ori. Unsupported kinds are accepted and dropped.
//   Each dropped request raises err_illegal for one cycle.
//
// Build option:
//   ENCODER_ORI_EN - when defined, kind 4 (ori) is encoded. When undefined,
//                    kind 4 is treated as illegal and no ori opcode logic
//                    exists in the design.
//
// Parameters:
//   DEPTH      - output FIFO entry count (2, 4 or 8).
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request can be accepted this cycle
//   req_kind   in   3   0=R, 1=lw, 2=sw, 3=beq, 4=ori, 5..7 illegal
//   req_rs     in   5   rs field
//   req_rt     in   5   rt field
//   req_rd     in   5   rd field (R-format only)
//   req_shamt  in   5   shift amount (R-format only)
//   req_funct  in   6   function field (R-format only)
//   req_imm    in  16   immediate / offset, passed through unmodified
//   out_valid  out  1   out_instr holds a valid word
//   out_ready  in   1   consumer takes the head word
//   out_instr  out 32   encoded word at the FIFO head
//   err_illegal out 1   one-cycle pulse after an illegal request is accepted
//   enc_count  out 16   words pushed since reset (wraps)
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_kind,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_shamt,
   input  logic [5:0]  req_funct,
   input  logic [15:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        err_illegal,
   output logic [15:0] enc_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Returns {legal, word}.
   function automatic logic [32:0] encode(
      input logic [2:0]  kind,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm
   );
      logic [32:0] r;
      r = '0;
      case (kind)
         3'd0:    r = {1'b1, 6'b000000, rs, rt, rd, shamt, funct};
         3'd1:    r = {1'b1, 6'b100011, rs, rt, imm};
         3'd2:    r = {1'b1, 6'b101011, rs, rt, imm};
         3'd3:    r = {1'b1, 6'b000100, rs, rt, imm};
`ifdef ENCODER_ORI_EN
         3'd4:    r = {1'b1, 6'b001101, rs, rt, imm};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             ready_en;   // held low in reset, set on first edge after
   logic [32:0]      enc;
   logic             legal;
   logic [31:0]      word;
   logic             req_fire;
   logic             push;
   logic             pop;

   always_comb begin
      enc   = encode(req_kind, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm);
      legal = enc[32];
      word  = enc[31:0];
   end

   // Fullness is judged before any same-cycle pop, so a full FIFO that is
   // draining still refuses this cycle's request.
   assign req_ready = ready_en && (count < DEPTH_C);
   assign out_valid = (count != '0);
   // Masking with occupancy keeps out_instr at zero in reset without
   // resetting the storage array.
   assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

   assign req_fire = req_valid && req_ready;
   assign push     = req_fire && legal;
   assign pop      = out_valid && out_ready;

   // Control state: pointers, occupancy, counters, error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_illegal <= 1'b0;
         enc_count   <= 16'h0;
      end else begin
         ready_en    <= 1'b1;
         err_illegal <= req_fire && !legal;
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;   // power-of-two depth wraps naturally
            enc_count <= enc_count + 16'h1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage: data only, no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= word;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed testbench for instr_encoder with the default DEPTH of 4. It checks
// reset state, encoding of each kind, FIFO ordering, behaviour when full,
// stall stability, illegal kinds, and asynchronous reset with buffered words.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_kind;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [4:0]  req_shamt;
   logic [5:0]  req_funct;
   logic [15:0] req_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        err_illegal;
   logic [15:0] enc_count;

   int errors = 0;
   int checks = 0;
   int exp_enc = 0;

   instr_encoder #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_kind    (req_kind),
      .req_rs      (req_rs),
      .req_rt      (req_rt),
      .req_rd      (req_rd),
      .req_shamt   (req_shamt),
      .req_funct   (req_funct),
      .req_imm     (req_imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .err_illegal (err_illegal),
      .enc_count   (enc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [2:0] k, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm);
      req_valid = v;
      req_kind  = k;
      req_rs    = rs;
      req_rt    = rt;
      req_rd    = rd;
      req_shamt = sh;
      req_funct = fn;
      req_imm   = imm;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0);

      // Reset state
      #2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_err", {31'b0, err_illegal}, 32'd0);
      chk("rst_enc_count", {16'b0, enc_count}, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

      // R-format, one-cycle latency into an empty FIFO
      set_req(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0);
      tick();
      exp_enc++;
      req_valid = 1'b0;
      chk("r_valid", {31'b0, out_valid}, 32'd1);
      chk("r_word", out_instr, 32'h00221820);
      chk("r_count", {16'b0, enc_count}, exp_enc);
      out_ready = 1'b1;
      tick();
      chk("r_drained", {31'b0, out_valid}, 32'd0);

      // lw then sw back to back with the consumer always ready
      set_req(1'b1, 3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004);
      tick();
      exp_enc++;
      chk("lw_word", out_instr, 32'h8FA80004);
      set_req(1'b1, 3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFC);
      tick();
      exp_enc++;
      req_valid = 1'b0;
      chk("sw_valid", {31'b0, out_valid}, 32'd1);
      chk("sw_word", out_instr, 32'hAFA8FFFC);
      tick();
      chk("lwsw_drained", {31'b0, out_valid}, 32'd0);
      chk("lwsw_count", {16'b0, enc_count}, exp_enc);

      // Fill the FIFO with four beq words while stalled
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i));
         tick();
         exp_enc++;
      end
      chk("full_ready", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      tick();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_word", out_instr, 32'h10220000);
      // Pop while full with a request pending: nothing may be pushed
      set_req(1'b1, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0009);
      out_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("full_no_push", {16'b0, enc_count}, exp_enc);
      chk("beq_1", out_instr, 32'h10220001);
      tick();
      chk("beq_2", out_instr, 32'h10220002);
      tick();
      chk("beq_3", out_instr, 32'h10220003);
      tick();
      chk("beq_drained", {31'b0, out_valid}, 32'd0);
      chk("beq_count", {16'b0, enc_count}, exp_enc);

      // ori: encoded only when the option is built in
      set_req(1'b1, 3'd4, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'h00FF);
      tick();
      req_valid = 1'b0;
`ifdef ENCODER_ORI_EN
      exp_enc++;
      chk("ori_valid", {31'b0, out_valid}, 32'd1);
      chk("ori_word", out_instr, 32'h340900FF);
      chk("ori_err", {31'b0, err_illegal}, 32'd0);
`else
      chk("ori_valid", {31'b0, out_valid}, 32'd0);
      chk("ori_err", {31'b0, err_illegal}, 32'd1);
`endif
      chk("ori_count", {16'b0, enc_count}, exp_enc);
      tick();
      chk("ori_err_end", {31'b0, err_illegal}, 32'd0);
      chk("ori_after", {31'b0, out_valid}, 32'd0);

      // Illegal kind 7
      set_req(1'b1, 3'd7, 5'd3, 5'd4, 5'd5, 5'd6, 6'd7, 16'h1234);
      tick();
      req_valid = 1'b0;
      chk("ill_err", {31'b0, err_illegal}, 32'd1);
      chk("ill_valid", {31'b0, out_valid}, 32'd0);
      chk("ill_count", {16'b0, enc_count}, exp_enc);
      tick();
      chk("ill_err_end", {31'b0, err_illegal}, 32'd0);

      // Reset in the middle of a stall with three words buffered
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 3'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'(16'hA0 + i));
         tick();
      end
      req_valid = 1'b0;
      chk("pre_rst_word", out_instr, 32'h8C8500A0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_ready", {31'b0, req_ready}, 32'd0);
      chk("arst_instr", out_instr, 32'h0);
      chk("arst_count", {16'b0, enc_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      set_req(1'b1, 3'd3, 5'd7, 5'd7, 5'd0, 5'd0, 6'd0, 16'hBEEF);
      tick();
      req_valid = 1'b0;
      chk("post_rst_word", out_instr, 32'h10E7BEEF);
      chk("post_rst_count", {16'b0, enc_count}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, sets the output FIFO entry count; legal values are 2, 4 and 8.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_kind  input  3  0=R-format, 1=lw, 2=sw, 3=beq, 4=ori, 5..7 illegal.
REQ-007 req_rs, req_rt, req_rd, req_shamt  input  5 each  register and shift fields.
REQ-008 req_funct  input  6  R-format function field.
REQ-009 req_imm  input  16  immediate or offset field.
REQ-010 out_valid  output  1  out_instr holds a valid word.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 out_instr  output  32  encoded instruction word at the FIFO head.
REQ-013 err_illegal  output  1  one-cycle pulse when an illegal request is accepted.
REQ-014 enc_count  output  16  number of words pushed since reset.

Function
REQ-015 A request transfer occurs on any cycle with req_valid=1 and req_ready=1; an output transfer occurs on any cycle with out_valid=1 and out_ready=1.
REQ-016 req_ready shall be 1 exactly when FIFO occupancy is below DEPTH, evaluated before any same-cycle pop.
- A full FIFO that is popping does not accept a push in that cycle.
REQ-017 Opcode encoding: R-format 000000, lw 100011, sw 101011, beq 000100, ori 001101; opcode occupies bits [31:26].
REQ-018 R-format word is {opcode, rs, rt, rd, shamt, funct}.
REQ-019 lw, sw, beq and ori words are {opcode, rs, rt, imm[15:0]}; imm is passed unmodified, with no sign handling.
REQ-020 Each legal transfer pushes one word into the FIFO tail in the same edge.
- out_valid rises on the next cycle.
- Latency from request to output word is 1 cycle when the FIFO is empty.
REQ-021 An illegal kind is consumed (req_ready behaves normally) but pushes nothing.
- err_illegal=1 for exactly the following cycle.
- enc_count is unchanged.
REQ-022 The FIFO is first-in first-out.
- out_instr and out_valid are driven from registers and do not change while out_valid=1 and out_ready=0.
REQ-023 On a simultaneous push and pop with occupancy between 1 and DEPTH-1, occupancy is unchanged and order is preserved.
REQ-024 Read and write pointers wrap modulo DEPTH.
REQ-025 enc_count increments by 1 per pushed word and wraps from 16'hFFFF to 0.
REQ-026 out_valid=0 whenever occupancy is 0; out_instr is don't-care while out_valid=0.

Reset
REQ-027 rst_n=0 immediately forces out_valid=0, req_ready=0, err_illegal=0, enc_count=0, occupancy=0 and out_instr=0.
REQ-028 Words buffered when reset asserts are discarded, including in the middle of a stall.
REQ-029 req_ready shall rise on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 Macro ENCODER_ORI_EN controls ori support.
- Defined: kind 4 encodes per REQ-019.
- Undefined: kind 4 is treated as illegal per REQ-021, and no 001101 opcode logic is synthesized.

Verification
REQ-031 Empty FIFO, push R-format rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> next cycle out_valid=1, out_instr=0x00221820.
REQ-032 Push lw rs=29 rt=8 imm=0x0004, then sw rs=29 rt=8 imm=0xFFFC, with out_ready=1 -> 0x8FA80004 then 0xAFA8FFFC on consecutive cycles; enc_count=2.
REQ-033 out_ready=0, push DEPTH beq words rs=1 rt=2 imm=0..3 -> req_ready=0 after the 4th push; then hold out_ready=1 with req_valid=1 -> no push while full, and output order 0x10220000..0x10220003.
REQ-034 Push kind 4 rs=0 rt=9 imm=0x00FF -> with ENCODER_ORI_EN 0x340900FF emitted; without it no word is emitted and err_illegal pulses for 1 cycle.
REQ-035 Push kind 7 -> err_illegal pulse, enc_count unchanged; separately, assert rst_n=0 with 3 words buffered and out_ready=0 -> out_valid=0 immediately, with no stale word after release.
